flag_unit: RTL
==============

// Module: flag_unit
// PURPOSE
//  Producer side of the branch-condition interface: owns the architectural NVZ flag register
//  that the branch PC logic consumes as F[2:0] = {Z,V,N}. Updates flags from EX-stage ALU results
//  per opcode rules. Either bypasses the in-flight update to a branch in ID or requests a stall.
//  Sits between EX (ALU) and ID (branch resolution) in the 5-stage WISC pipeline.
// PARAMETERS
//  FWD_EN    1   1: bypass EX flag update to ID branch; 0: stall ID branch one cycle instead
//  CNT_W     16  width of saturating flag-hazard event counter
// PORTS
//  clk           in   1      pipeline clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  ex_valid      in   1      EX holds a real (non-bubble) instruction
//  ex_flush      in   1      kill EX instruction this cycle (no flag write)
//  ex_stall      in   1      EX held this cycle (no flag write; instruction re-presented)
//  ex_opcode     in   4      opcode of EX instruction
//  alu_result    in   16     ALU result (post-saturation)
//  alu_ovfl      in   1      ALU signed overflow (ADD/SUB only meaningful)
//  id_is_branch  in   1      ID holds B or BR needing flags this cycle
//  F             out  3      flags to branch logic, {Z,V,N}: registered or bypassed per FWD_EN
//  F_q           out  3      raw architectural flag register {Z,V,N}
//  flag_stall    out  1      stall IF/ID, bubble EX (only when FWD_EN=0)
//  hazard_cnt    out  CNT_W  count of cycles where id_is_branch met an in-flight flag writer
// BEHAVIOUR
//  Reset (async, rst_n=0): F_q=3'b000, hazard_cnt=0; F=000, flag_stall=0 while reset held.
//  Update mask by opcode: ADD 0000, SUB 0001 -> {Z,V,N}; XOR 0010, SLL 0100, SRA 0101,
//   ROR 0110 -> {Z} only; all other opcodes (RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT) -> none.
//  New values: Z = (alu_result==16'h0000); N = alu_result[15]; V = alu_ovfl.
//  wr_en = ex_valid & ~ex_flush & ~ex_stall & (mask != 0). On posedge with wr_en, masked bits of
//   F_q take new values, unmasked bits hold. Latency: visible on F_q the cycle after EX.
//  flush and stall both high -> no write (flush wins; stall is irrelevant).
//  hazard = id_is_branch & ex_valid & ~ex_flush & (mask != 0).
//  FWD_EN=1: F = hazard ? merged(F_q, new, mask) : F_q (combinational, same cycle);
//   flag_stall tied 0.
//  FWD_EN=0: F = F_q; flag_stall = hazard. Pipeline inserts bubble into EX next cycle, so
//   hazard drops once writer commits; stall lasts exactly one cycle per writer.
//  Back-to-back writers (e.g. ADD then XOR): each updates only its mask bits; XOR keeps V,N from ADD.
//  hazard_cnt: +1 on each posedge where hazard=1; saturates at all-ones, no wrap.
//  Reset mid-stall: flag_stall deasserts asynchronously with rst_n low; no partial flag write.
//  No X propagation: all outputs defined from reset; ex_opcode ignored when ex_valid=0.
// STRUCTURE
//  Shared package wisc_pkg: opcode localparams (OP_ADD..OP_HLT), flag index constants
//   FLG_Z=2, FLG_V=1, FLG_N=0, typedef logic [2:0] flags_t.
//  One sub-module: flag_mask_decode (opcode -> 3-bit update mask, pure combinational).
//  Top: flag register, write gating, bypass mux, hazard/stall logic, saturating counter.
// TESTING
//  1 Reset: rst_n=0 with ADD valid -> F_q=000, hazard_cnt=0; release -> first ADD writes on next edge.
//  2 ADD result 16'h0000, ovfl=0 -> F_q=100; then SUB result 16'h8000, ovfl=1 -> F_q=011.
//  3 F_q=011, XOR result 0 -> F_q=111 (V,N held); LW/LLB/PADDSB result 0 -> F_q unchanged.
//  4 FWD_EN=1: SUB result 0 in EX + id_is_branch -> F=100 same cycle, flag_stall=0, hazard_cnt+1.
//  5 FWD_EN=0: same stimulus -> flag_stall=1 one cycle, F=old F_q; next cycle (bubble) F=100, stall=0.
//  6 ex_flush=1 on ADD result 0 -> no write, hazard=0; ex_stall=1 -> no write until released;
//    CNT_W=2, 5 hazards -> hazard_cnt saturates at 3.

Source files
------------

// File: rtl/wisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wisc_pkg
// Description : Shared WISC pipeline definitions: opcode encodings, NVZ flag
//               bit positions, flag vector type and a masked-merge helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

  typedef logic [2:0] flags_t;

  // Bits selected by mask come from upd, the rest keep old.
  function automatic flags_t merge_flags(input flags_t old, input flags_t upd,
                                         input flags_t mask);
    return (old & ~mask) | (upd & mask);
  endfunction

endpackage : wisc_pkg
`default_nettype wire

// File: rtl/flag_mask_decode.sv
`default_nettype none
// ============================================================================
// Module      : flag_mask_decode
// Description : Maps an opcode to the set of NVZ flags it updates.
// Ports       : opcode_i  in  4  instruction opcode
//               mask_o    out 3  update mask {Z,V,N}
// Revision    : 1.0 - initial release
// ============================================================================
module flag_mask_decode
  import wisc_pkg::*;
(
  input  logic [3:0] opcode_i,
  output flags_t     mask_o
);

  always_comb begin
    mask_o = '0;
    case (opcode_i)
      OP_ADD, OP_SUB: begin
        mask_o[FLG_Z] = 1'b1;
        mask_o[FLG_V] = 1'b1;
        mask_o[FLG_N] = 1'b1;
      end
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
        mask_o[FLG_Z] = 1'b1;
      end
      default: mask_o = '0;
    endcase
  end

endmodule : flag_mask_decode
`default_nettype wire

// File: rtl/flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : flag_unit
// Description : Architectural NVZ flag register fed from the EX stage, with
//               either a same-cycle bypass to an ID branch (FWD_EN=1) or a
//               one-cycle stall request (FWD_EN=0), plus a saturating count
//               of flag-hazard cycles.
// Ports       : clk, rst_n                  clock, async active-low reset
//               ex_valid/ex_flush/ex_stall  EX instruction qualifiers
//               ex_opcode [3:0]             EX opcode
//               alu_result [15:0], alu_ovfl ALU outputs
//               id_is_branch                ID branch needs flags
//               F [2:0]                     flags to branch logic {Z,V,N}
//               F_q [2:0]                   architectural flag register
//               flag_stall                  stall request (FWD_EN=0 only)
//               hazard_cnt [CNT_W-1:0]      saturating hazard counter
// Revision    : 1.0 - initial release
// ============================================================================
module flag_unit
  import wisc_pkg::*;
#(
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_flush,
  input  logic             ex_stall,
  input  logic [3:0]       ex_opcode,
  input  logic [15:0]      alu_result,
  input  logic             alu_ovfl,
  input  logic             id_is_branch,
  output logic [2:0]       F,
  output logic [2:0]       F_q,
  output logic             flag_stall,
  output logic [CNT_W-1:0] hazard_cnt
);

  flags_t            w_mask;
  flags_t            w_new;
  flags_t            w_merged;
  logic [3:0]        w_opcode;
  logic              w_wr_en;
  logic              w_hazard;
  logic              w_hazard_live;
  flags_t            flags_q, flags_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Bubbles decode as HLT so a stale/undefined opcode never reaches the mask.
  assign w_opcode = ex_valid ? ex_opcode : OP_HLT;

  flag_mask_decode u_mask (
    .opcode_i (w_opcode),
    .mask_o   (w_mask)
  );

  always_comb begin
    w_new        = '0;
    w_new[FLG_Z] = ~|alu_result;
    w_new[FLG_V] = alu_ovfl;
    w_new[FLG_N] = alu_result[15];
  end

  assign w_merged = merge_flags(flags_q, w_new, w_mask);

  // A stalled EX instruction is still in flight (it will write later), so it
  // counts as a hazard; a flushed one never writes, so it does not.
  assign w_wr_en  = ex_valid & ~ex_flush & ~ex_stall & (|w_mask);
  assign w_hazard = id_is_branch & ex_valid & ~ex_flush & (|w_mask);

  // Keeps F and flag_stall quiet while reset is held, independent of inputs.
  assign w_hazard_live = w_hazard & rst_n;

  assign flags_d = w_wr_en ? w_merged : flags_q;
  assign cnt_d   = (w_hazard && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  generate
    if (FWD_EN != 0) begin : g_fwd
      assign F          = w_hazard_live ? w_merged : flags_q;
      assign flag_stall = 1'b0;
    end else begin : g_stall
      assign F          = flags_q;
      assign flag_stall = w_hazard_live;
    end
  endgenerate

  assign F_q        = flags_q;
  assign hazard_cnt = cnt_q;

endmodule : flag_unit
`default_nettype wire
